// File: rtl/branch_unit.sv
// Branch resolution unit: decodes conditional branches, resolves them and
// trains a 2-bit saturating branch history table used for fetch prediction.
module branch_unit #(
    parameter int DATA_W    = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pred_pc,
    output logic              pred_taken,
    input  logic              res_valid,
    input  logic              stall,
    input  logic [31:0]       res_pc,
    input  logic [5:0]        op,
    input  logic [4:0]        rt,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              res_pred,
    output logic              res_taken,
    output logic              mispredict,
    output logic              is_branch,
    output logic [CNT_W-1:0]  mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] pidx;
    logic [IDX_W-1:0] ridx;
    logic             br;
    logic             cond;
    logic             upd;
    logic             miss;
    logic             sign_a;
    logic             zero_a;
    logic             unused;

    assign pidx       = pred_pc[IDX_W+1:2];
    assign ridx       = res_pc[IDX_W+1:2];
    assign pred_taken = bht[pidx][1];
    assign sign_a     = a[DATA_W-1];
    assign zero_a     = ~|a;
    assign unused     = ^{pred_pc[31:IDX_W+2], pred_pc[1:0],
                          res_pc[31:IDX_W+2], res_pc[1:0]};

    always_comb begin
        br   = 1'b0;
        cond = 1'b0;
        case (op)
            6'b000100: begin br = 1'b1; cond = (a == b);           end
            6'b000101: begin br = 1'b1; cond = (a != b);           end
            6'b000110: begin br = 1'b1; cond = sign_a | zero_a;    end
            6'b000111: begin br = 1'b1; cond = ~sign_a & ~zero_a;  end
            6'b000001: begin
                // REGIMM: the link variants share the plain condition
                case (rt)
                    5'b00000, 5'b10000: begin br = 1'b1; cond = sign_a;  end
                    5'b00001, 5'b10001: begin br = 1'b1; cond = ~sign_a; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign upd  = res_valid & ~stall & br;
    assign miss = upd & (res_pred != cond);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
            mispredict_cnt <= '0;
            res_taken      <= 1'b0;
            is_branch      <= 1'b0;
            mispredict     <= 1'b0;
        end else begin
            res_taken  <= upd & cond;
            is_branch  <= upd;
            mispredict <= miss;
            if (upd) begin
                if (cond && bht[ridx] != 2'b11)
                    bht[ridx] <= bht[ridx] + 2'd1;
                else if (!cond && bht[ridx] != 2'b00)
                    bht[ridx] <= bht[ridx] - 2'd1;
            end
            if (miss) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Testbench for branch_unit: directed scenarios plus randomized traffic
// compared every cycle against a behavioural predictor model.
module tb_branch_unit;

    localparam int DW = 32;
    localparam int DEPTH = 64;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   pred_pc = '0;
    logic          pred_taken;
    logic          res_valid = 1'b0;
    logic          stall = 1'b0;
    logic [31:0]   res_pc = '0;
    logic [5:0]    op = '0;
    logic [4:0]    rt = '0;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic          res_pred = 1'b0;
    logic          res_taken;
    logic          mispredict;
    logic          is_branch;
    logic [CW-1:0] mispredict_cnt;

    int tests = 0;
    int fails = 0;

    int  bht_m [DEPTH];
    int  cnt_m = 0;
    bit  e_t = 0, e_b = 0, e_m = 0;
    bit  ready = 0;

    branch_unit #(.DATA_W(DW), .BHT_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .res_valid(res_valid), .stall(stall), .res_pc(res_pc), .op(op),
        .rt(rt), .a(a), .b(b), .res_pred(res_pred), .res_taken(res_taken),
        .mispredict(mispredict), .is_branch(is_branch),
        .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_eval(input logic [5:0] o, input logic [4:0] r,
                                     input logic [DW-1:0] x, input logic [DW-1:0] y,
                                     output bit br, output bit tk);
        logic signed [DW-1:0] sx;
        sx = x;
        br = 0;
        tk = 0;
        case (o)
            6'd4: begin br = 1; tk = (x == y); end
            6'd5: begin br = 1; tk = (x != y); end
            6'd6: begin br = 1; tk = (sx <= 0); end
            6'd7: begin br = 1; tk = (sx > 0);  end
            6'd1: begin
                if (r == 5'd0 || r == 5'd16) begin br = 1; tk = (sx < 0); end
                if (r == 5'd1 || r == 5'd17) begin br = 1; tk = (sx >= 0); end
            end
            default: ;
        endcase
    endfunction

    // reference model, advanced on each rising edge
    always @(posedge clk) begin
        bit br, tk;
        int idx;
        if (rst) begin
            foreach (bht_m[i]) bht_m[i] = 1;
            cnt_m = 0;
            e_t = 0; e_b = 0; e_m = 0;
            ready = 1;
        end else begin
            e_t = 0; e_b = 0; e_m = 0;
            if (res_valid && !stall) begin
                ref_eval(op, rt, a, b, br, tk);
                if (br) begin
                    idx = (res_pc / 4) % DEPTH;
                    e_b = 1;
                    e_t = tk;
                    e_m = (res_pred != tk);
                    if (tk) bht_m[idx] = (bht_m[idx] == 3) ? 3 : bht_m[idx] + 1;
                    else    bht_m[idx] = (bht_m[idx] == 0) ? 0 : bht_m[idx] - 1;
                    if (e_m) cnt_m = (cnt_m + 1) % (1 << CW);
                end
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (ready) begin
            chk("pred_taken", pred_taken, bht_m[(pred_pc / 4) % DEPTH] >= 2);
            chk("res_taken", res_taken, e_t);
            chk("is_branch", is_branch, e_b);
            chk("mispredict", mispredict, e_m);
            chk("mispredict_cnt", mispredict_cnt, cnt_m);
        end
    end

    task automatic drive(input bit v, input bit s, input logic [31:0] pc,
                         input logic [5:0] o, input logic [4:0] r,
                         input logic [DW-1:0] x, input logic [DW-1:0] y,
                         input bit p);
        res_valid = v; stall = s; res_pc = pc; op = o; rt = r;
        a = x; b = y; res_pred = p;
        @(posedge clk); #1;
        res_valid = 0; stall = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    logic [DW-1:0] vals [6];

    initial begin
        vals[0] = 0; vals[1] = 1; vals[2] = 32'h7fffffff;
        vals[3] = 32'h80000000; vals[4] = 32'hffffffff; vals[5] = 5;

        // reset state and first-cycle predictions
        do_reset();
        chk("rst_res_taken", res_taken, 0);
        chk("rst_is_branch", is_branch, 0);
        chk("rst_cnt", mispredict_cnt, 0);
        for (int i = 0; i < DEPTH; i++) begin
            pred_pc = 32'(i * 4) | 32'h1000;
            #1 chk("rst_pred", pred_taken, 0);
        end

        // BEQ taken, initially predicted not taken
        do_reset();
        pred_pc = 0;
        drive(1, 0, 32'h40, 6'd4, 5'd0, 5, 5, 0);
        chk("beq_taken", res_taken, 1);
        chk("beq_isbr", is_branch, 1);
        chk("beq_misp", mispredict, 1);
        chk("beq_cnt", mispredict_cnt, 1);
        chk("beq_ent16", bht_m[16], 2);
        pred_pc = 32'h40;
        #1 chk("beq_pred", pred_taken, 1);

        // BGTZ saturation then negative operand
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h80, 6'd7, 5'd0, 1, 0, 0);
            chk("bgtz_taken", res_taken, 1);
            chk("bgtz_ent32", bht_m[32], (i == 0) ? 2 : 3);
        end
        drive(1, 0, 32'h80, 6'd7, 5'd0, 32'h80000000, 0, 0);
        chk("bgtz_neg", res_taken, 0);
        chk("bgtz_neg_ent", bht_m[32], 2);
        chk("bgtz_cnt", mispredict_cnt, 3);

        // REGIMM link forms and a non-branch opcode
        drive(1, 0, 32'hC0, 6'd1, 5'd17, 32'hffffffff, 0, 1);
        chk("bgezal_taken", res_taken, 0);
        chk("bgezal_isbr", is_branch, 1);
        drive(1, 0, 32'hC0, 6'd1, 5'd16, 32'hffffffff, 0, 1);
        chk("bltzal_taken", res_taken, 1);
        drive(1, 0, 32'hC0, 6'd0, 5'd0, 0, 0, 1);
        chk("special_isbr", is_branch, 0);
        chk("special_misp", mispredict, 0);
        chk("special_cnt", mispredict_cnt, 4);

        // same-index lookup during update: no bypass
        do_reset();
        pred_pc = 32'h40;
        res_valid = 1; stall = 0; res_pc = 32'h40; op = 6'd4; rt = 0;
        a = 9; b = 9; res_pred = 0;
        #2 chk("nobypass_same", pred_taken, 0);
        @(posedge clk); #1;
        res_valid = 0;
        chk("nobypass_next", pred_taken, 1);

        // stalled resolution is ignored
        drive(1, 1, 32'h40, 6'd5, 5'd0, 1, 2, 0);
        chk("stall_taken", res_taken, 0);
        chk("stall_isbr", is_branch, 0);
        chk("stall_cnt", mispredict_cnt, 1);
        chk("stall_ent", bht_m[16], 2);

        // reset beats a simultaneous mispredicting branch
        do_reset();
        for (int i = 0; i < 7; i++)
            drive(1, 0, 32'(i * 4), 6'd4, 5'd0, 3, 3, 0);
        chk("pre_rst_cnt", mispredict_cnt, 7);
        rst = 1;
        drive(1, 0, 32'h40, 6'd4, 5'd0, 3, 3, 0);
        rst = 0;
        chk("rst_pri_cnt", mispredict_cnt, 0);
        chk("rst_pri_misp", mispredict, 0);
        chk("rst_pri_ent", bht_m[16], 1);
        pred_pc = 0;
        #1 chk("rst_pri_pred", pred_taken, 0);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            logic [5:0] o;
            logic [4:0] r;
            logic [DW-1:0] x, y;
            case ($urandom_range(0, 6))
                0: o = 6'd4;
                1: o = 6'd5;
                2: o = 6'd6;
                3: o = 6'd7;
                4, 5: o = 6'd1;
                default: o = 6'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: r = 5'd0;
                1: r = 5'd1;
                2: r = 5'd16;
                3: r = 5'd17;
                default: r = 5'($urandom);
            endcase
            x = ($urandom_range(0, 1) != 0) ? vals[$urandom_range(0, 5)] : $urandom;
            y = ($urandom_range(0, 2) == 0) ? x : vals[$urandom_range(0, 5)];
            pred_pc = $urandom;
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  $urandom & 32'hfffff1ff, o, r, x, y, $urandom_range(0, 1) != 0);
        end
        rst = 0;
        @(posedge clk); #1;
        @(negedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 Parameter DATA_W, default 32, operand width compared by the branch condition logic.
REQ-002 Parameter BHT_DEPTH, default 64, number of 2-bit history counters; power of two, 4..1024; IDX_W = log2(BHT_DEPTH).
REQ-003 Parameter CNT_W, default 32, width of the misprediction statistics counter.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port pred_pc  input  32  fetch-stage PC for prediction lookup.
REQ-007 Port pred_taken  output  1  combinational prediction, counter MSB of entry pred_pc[IDX_W+1:2].
REQ-008 Port res_valid  input  1  resolution request valid this cycle.
REQ-009 Port stall  input  1  pipeline stall; blocks all resolution state updates.
REQ-010 Port res_pc  input  32  PC of the instruction being resolved.
REQ-011 Port op  input  6  instruction opcode field.
REQ-012 Port rt  input  5  instruction rt field (REGIMM sub-opcode).
REQ-013 Port a, b  input  DATA_W each  rs and rt operand values, already forwarded.
REQ-014 Port res_pred  input  1  prediction originally used for this instruction.
REQ-015 Port res_taken  output  1  registered actual branch outcome.
REQ-016 Port mispredict  output  1  registered, one-cycle pulse: res_pred differs from actual outcome.
REQ-017 Port is_branch  output  1  registered: resolved instruction was a conditional branch.
REQ-018 Port mispredict_cnt  output  CNT_W  total mispredictions since reset.

Function
REQ-019 Branch decode SHALL recognise BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111, and REGIMM 000001 with rt BLTZ 00000, BGEZ 00001, BLTZAL 10000, BGEZAL 10001; any other op/rt is not a branch.
REQ-020 Conditions: BEQ a==b; BNE a!=b; BGEZ/BGEZAL a[DATA_W-1]==0; BLTZ/BLTZAL a[DATA_W-1]==1; BGTZ signed a>0; BLEZ signed a<=0; comparisons at full DATA_W; b ignored except BEQ/BNE.
REQ-021 A resolution is accepted in a cycle where res_valid=1 and stall=0; outputs res_taken, is_branch, mispredict reflect that request in the following cycle (latency 1).
REQ-022 Cycle with no accepted request: res_taken, is_branch, mispredict SHALL be 0 next cycle; when the accepted request is a non-branch, all three SHALL be 0 and no table or counter update occurs.
REQ-023 Each BHT entry SHALL be a 2-bit saturating counter: 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken.
REQ-024 Accepted branch updates entry res_pc[IDX_W+1:2] at the same clock edge: taken increments and saturates at 11; not-taken decrements and saturates at 00.
REQ-025 mispredict SHALL be asserted only for an accepted branch with res_pred != actual outcome; mispredict_cnt increments at the same edge and wraps from all-ones to 0.
REQ-026 Same-index lookup and update in one cycle: pred_taken SHALL return the pre-update value; the new value is visible from the next cycle; no bypass.
REQ-027 res_pc and pred_pc bits outside the index field SHALL NOT affect behaviour (aliasing accepted).
REQ-028 stall=1 with res_valid=1: no table, counter or output-register update except that outputs go to 0 per REQ-022.

Reset
REQ-029 While rst=1 at a clock edge: every BHT entry becomes 01, mispredict_cnt becomes 0, res_taken, is_branch, mispredict become 0.
REQ-030 rst SHALL take priority over any simultaneous accepted resolution; that resolution is discarded and uncounted.
REQ-031 pred_taken SHALL read 0 for every index in the first cycle after reset.

Verification
REQ-032 Reset, then BEQ a=b=0x00000005, res_pc=0x40, res_pred=0 -> next cycle res_taken=1, is_branch=1, mispredict=1, mispredict_cnt=1; entry 16 becomes 10; pred_pc=0x40 gives pred_taken=1.
REQ-033 Three consecutive taken BGTZ a=0x00000001 at res_pc=0x80 from reset -> entry 32 sequence 10,11,11 (saturates); then BGTZ a=0x80000000 -> not taken, entry 10.
REQ-034 REGIMM rt=10001 a=0xFFFFFFFF -> not taken; rt=10000 same a -> taken; op=000000 (SPECIAL) -> is_branch=0, no counter change.
REQ-035 Lookup pred_pc=0x40 in same cycle as taken update of res_pc=0x40 with entry 01 -> pred_taken=0 that cycle, 1 next cycle.
REQ-036 res_valid=1, stall=1, BNE a=1 b=2 res_pred=0 -> outputs 0, mispredict_cnt unchanged, entry unchanged.
REQ-037 rst asserted in same cycle as mispredicting branch after mispredict_cnt=7 -> next cycle mispredict_cnt=0, mispredict=0, all entries 01.
